// File: rtl/ieee_adder.sv
// ieee_adder: 2-stage pipelined IEEE-754 binary32 add/subtract, round-to-nearest-even, no handshake.
// Define IEEE_ADDER_SUBNORMAL_EN for gradual underflow; otherwise subnormal inputs/results flush to zero.
module ieee_adder (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        add_sub_bit,
  input  logic [31:0] inputA,
  input  logic [31:0] inputB,
  output logic [31:0] outputC
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  // ---------------- Stage 1: unpack, swap, align, add ----------------
  logic [7:0]  w_ea_raw, w_eb_raw, w_ea, w_eb;
  logic [23:0] w_ma, w_mb;
  logic        w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf;

  assign w_ea_raw = inputA[30:23];
  assign w_eb_raw = inputB[30:23];
  assign w_sa     = inputA[31];
  assign w_sb     = inputB[31] ^ add_sub_bit;
  assign w_a_nan  = (&w_ea_raw) & (|inputA[22:0]);
  assign w_b_nan  = (&w_eb_raw) & (|inputB[22:0]);
  assign w_a_inf  = (&w_ea_raw) & ~(|inputA[22:0]);
  assign w_b_inf  = (&w_eb_raw) & ~(|inputB[22:0]);
  assign w_ea     = (w_ea_raw == 8'd0) ? 8'd1 : w_ea_raw;
  assign w_eb     = (w_eb_raw == 8'd0) ? 8'd1 : w_eb_raw;

`ifdef IEEE_ADDER_SUBNORMAL_EN
  assign w_ma = {|w_ea_raw, inputA[22:0]};
  assign w_mb = {|w_eb_raw, inputB[22:0]};
`else
  assign w_ma = (w_ea_raw == 8'd0) ? 24'd0 : {1'b1, inputA[22:0]};
  assign w_mb = (w_eb_raw == 8'd0) ? 24'd0 : {1'b1, inputB[22:0]};
`endif

  logic        w_a_ge_b, w_s_big, w_eff_sub, w_sign;
  logic [7:0]  w_e_big, w_e_small, w_diff;
  logic [23:0] w_m_big, w_m_small;
  logic [52:0] w_sh_full;
  logic [26:0] w_aligned;
  logic [27:0] w_sum;

  assign w_a_ge_b  = {w_ea, w_ma} >= {w_eb, w_mb};
  assign w_e_big   = w_a_ge_b ? w_ea : w_eb;
  assign w_e_small = w_a_ge_b ? w_eb : w_ea;
  assign w_m_big   = w_a_ge_b ? w_ma : w_mb;
  assign w_m_small = w_a_ge_b ? w_mb : w_ma;
  assign w_s_big   = w_a_ge_b ? w_sa : w_sb;
  assign w_diff    = w_e_big - w_e_small;
  assign w_eff_sub = w_sa ^ w_sb;

  // 27-bit window is {significand, guard, round, sticky}; everything shifted below it ORs into sticky
  assign w_sh_full = {w_m_small, 29'd0} >> w_diff;
  assign w_aligned = (w_diff >= 8'd26) ? {26'd0, |w_m_small}
                                       : {w_sh_full[52:27], w_sh_full[26] | (|w_sh_full[25:0])};
  assign w_sum     = w_eff_sub ? ({1'b0, w_m_big, 3'b000} - {1'b0, w_aligned})
                               : ({1'b0, w_m_big, 3'b000} + {1'b0, w_aligned});
  assign w_sign    = (w_eff_sub && (w_sum == 28'd0)) ? 1'b0 : w_s_big;

  logic [27:0] r_sum;
  logic [7:0]  r_exp;
  logic        r_sign, r_nan, r_inf, r_inf_sign;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_sum      <= '0;
      r_exp      <= '0;
      r_sign     <= 1'b0;
      r_nan      <= 1'b0;
      r_inf      <= 1'b0;
      r_inf_sign <= 1'b0;
    end else begin
      r_sum      <= w_sum;
      r_exp      <= w_e_big;
      r_sign     <= w_sign;
      r_nan      <= w_a_nan | w_b_nan | (w_a_inf & w_b_inf & w_eff_sub);
      r_inf      <= w_a_inf | w_b_inf;
      r_inf_sign <= w_a_inf ? w_sa : w_sb;
    end
  end

  // ---------------- Stage 2: normalise, round, pack ----------------
  logic [4:0]        w_lz, w_shamt;
  logic [26:0]       w_norm;
  logic signed [9:0] w_nexp, w_fexp;
  logic              w_up;
  logic [24:0]       w_mr;
  logic [23:0]       w_mant;
  logic [31:0]       w_result;

  assign w_lz = lzc27(r_sum[26:0]);

`ifdef IEEE_ADDER_SUBNORMAL_EN
  // Stop the left shift at exponent 1 so tiny results land as subnormals
  logic [7:0] w_limit;
  assign w_limit = (r_exp == 8'd0) ? 8'd0 : r_exp - 8'd1;
  assign w_shamt = ({3'd0, w_lz} > w_limit) ? w_limit[4:0] : w_lz;
`else
  assign w_shamt = w_lz;
`endif

  always_comb begin
    w_norm = r_sum[26:0];
    w_nexp = $signed({2'b00, r_exp});
    if (r_sum[27]) begin
      w_norm = {r_sum[27:2], r_sum[1] | r_sum[0]};
      w_nexp = $signed({2'b00, r_exp}) + 10'sd1;
    end else begin
      w_norm = r_sum[26:0] << w_shamt;
      w_nexp = $signed({2'b00, r_exp}) - $signed({5'd0, w_shamt});
    end
  end

  assign w_up   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_mr   = {1'b0, w_norm[26:3]} + {24'd0, w_up};
  assign w_mant = w_mr[24] ? w_mr[24:1] : w_mr[23:0];
  assign w_fexp = w_mr[24] ? (w_nexp + 10'sd1) : w_nexp;

  always_comb begin
    w_result = {r_sign, (w_mant[23] ? w_fexp[7:0] : 8'd0), w_mant[22:0]};
    if (r_nan)
      w_result = 32'h7FC0_0000;
    else if (r_inf)
      w_result = {r_inf_sign, 8'hFF, 23'd0};
    else if (w_fexp >= 10'sd255)
      w_result = {r_sign, 8'hFF, 23'd0};
`ifndef IEEE_ADDER_SUBNORMAL_EN
    else if (w_nexp < 10'sd1)
      w_result = {r_sign, 31'd0};
`endif
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) outputC <= '0;
    else          outputC <= w_result;
  end

endmodule

// File: tb/tb_ieee_adder.sv
// Scoreboarded bench for ieee_adder: directed binary32 vectors streamed back-to-back, reset mid-stream.
module tb_ieee_adder;
  logic        clock_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        add_sub_bit = 1'b0;
  logic [31:0] inputA = '0;
  logic [31:0] inputB = '0;
  logic [31:0] outputC;

  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    int          id;
    logic [31:0] val;
  } sb_t;
  sb_t sb_q[$];

  ieee_adder dut (
    .clock_in    (clock_in),
    .reset_in    (reset_in),
    .add_sub_bit (add_sub_bit),
    .inputA      (inputA),
    .inputB      (inputB),
    .outputC     (outputC)
  );

  always #5 clock_in = ~clock_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] val);
    sb_t e;
    e.id  = id;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // One vector per cycle; result for a vector driven at negedge k is checked at negedge k+2
  task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [31:0] expv);
    sb_t e;
    @(negedge clock_in);
    if (sb_q.size() >= 2) begin
      e = sb_q.pop_front();
      check_val($sformatf("vec%0d", e.id), outputC, e.val);
    end
    inputA      = a;
    inputB      = b;
    add_sub_bit = op;
    push_exp(id, expv);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clock_in);
    reset_in = 1'b1;
    sb_q.delete();
    #1 check_val("rst_async", outputC, 32'h0);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock_in);
      check_val("rst_hold", outputC, 32'h0);
    end
    inputA      = '0;
    inputB      = '0;
    add_sub_bit = 1'b0;
    reset_in    = 1'b0;
    // first output after release comes from cleared stage 1, second from the 0+0 sampled now
    push_exp(-1, 32'h0);
    push_exp(-2, 32'h0);
  endtask

  task automatic drain();
    sb_t e;
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) begin
      @(negedge clock_in);
      e = sb_q.pop_front();
      check_val($sformatf("vec%0d", e.id), outputC, e.val);
    end
  endtask

  initial begin
    #1 check_val("reset_state", outputC, 32'h0);
    do_reset(2);

    drive( 1, 32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000); // 1.5+0.5
    drive( 2, 32'h3FC00000, 32'h3F000000, 1'b1, 32'h3F800000); // 1.5-0.5
    drive( 3, 32'h40400000, 32'hC0400000, 1'b0, 32'h00000000); // exact cancel
    drive( 4, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000); // -0 + -0
    drive( 5, 32'h00000000, 32'h80000000, 1'b0, 32'h00000000); // +0 + -0
    drive( 6, 32'h41000000, 32'h3FC00000, 1'b0, 32'h41180000); // 8+1.5
    drive( 7, 32'h3FC00000, 32'h41000000, 1'b0, 32'h41180000); // swapped
    drive( 8, 32'h40A00000, 32'h40800000, 1'b1, 32'h3F800000); // 5-4
    drive( 9, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000); // overflow
    drive(10, 32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000); // neg overflow
    drive(11, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000); // inf-inf
    drive(12, 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000); // NaN in
    drive(13, 32'h3F800000, 32'h7F800001, 1'b1, 32'h7FC00000); // signalling NaN in B
    drive(14, 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000); // -inf + finite
    drive(15, 32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000); // inf+inf
    drive(16, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000); // tie, even stays
    drive(17, 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001); // above half
    drive(18, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002); // tie, odd rounds up
    drive(19, 32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000); // round carry renorm
    drive(20, 32'h3F800000, 32'h00800000, 1'b1, 32'h3F800000); // sticky-only subtract
    drive(21, 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000); // massive cancellation
    drive(22, 32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000); // overflow via rounding
    drive(23, 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000); // tiny + 1
`ifdef IEEE_ADDER_SUBNORMAL_EN
    drive(24, 32'h80C00001, 32'h00800000, 1'b0, 32'h80400001);
    drive(25, 32'h00400000, 32'h00400000, 1'b0, 32'h00800000);
    drive(26, 32'h80000001, 32'h80000001, 1'b0, 32'h80000002);
`else
    drive(24, 32'h80C00001, 32'h00800000, 1'b0, 32'h80000000);
    drive(25, 32'h00400000, 32'h00400000, 1'b0, 32'h00000000);
    drive(26, 32'h80000001, 32'h80000001, 1'b0, 32'h80000000);
`endif

    // reset with nonzero results still in flight
    drive(27, 32'h41000000, 32'h3FC00000, 1'b0, 32'h41180000);
    drive(28, 32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000);
    do_reset(2);
    drive(29, 32'h40A00000, 32'h40800000, 1'b1, 32'h3F800000);
    drive(30, 32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000);
    drive(31, 32'h40400000, 32'hC0400000, 1'b0, 32'h00000000);
    drive(32, 32'hBF800000, 32'h3F800000, 1'b0, 32'h80000000 ^ 32'h80000000); // -1+1
    drive(33, 32'hBFC00000, 32'h3F000000, 1'b0, 32'hBF800000);              // -1.5+0.5
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, %0d checks done", n_chk);
    $fatal(1);
  end

endmodule

// File: doc/ieee_adder.md
IEEE_ADDER -- requirements
Module: ieee_adder

Interface
REQ-001 Parameters: none; format fixed to IEEE-754 binary32.
REQ-002 clock_in  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_in  input  1  asynchronous, active-high reset.
REQ-004 add_sub_bit  input  1  0 = inputA + inputB; 1 = inputA - inputB (sign of inputB inverted before the add).
REQ-005 inputA  input  32  binary32 operand A: bit 31 sign, 30:23 exponent (bias 127), 22:0 fraction.
REQ-006 inputB  input  32  binary32 operand B, same layout.
REQ-007 outputC  output  32  registered binary32 result.

Function
REQ-008 The block SHALL be a fully pipelined adder accepting one operation every cycle, with no handshake.
REQ-009 Latency SHALL be exactly 2 rising edges: operands sampled at edge N appear on outputC after edge N+1 and hold until the next update.
REQ-010 Operation SHALL be effective add or subtract by comparing signs after applying add_sub_bit; the larger-magnitude operand sets the result sign.
REQ-011 Alignment SHALL shift the smaller significand right by the exponent difference, keeping guard, round and sticky bits; shifts of 26 or more reduce that operand to sticky only.
REQ-012 After add or subtract, the result SHALL be normalised: 1-bit right shift with exponent +1 on carry-out; leading-zero count and left shift on cancellation.
REQ-013 Rounding SHALL be round-to-nearest, ties-to-even; rounding carry into bit 24 SHALL renormalise and increment the exponent.
REQ-014 Exact cancellation (x + -x) SHALL yield +0 (0x00000000); (-0) + (-0) SHALL yield -0 (0x80000000); (+0) + (-0) SHALL yield +0.
REQ-015 Exponent overflow after rounding SHALL yield signed infinity (0x7F800000 / 0xFF800000).
REQ-016 Any NaN input, or Inf + (-Inf) after applying add_sub_bit, SHALL yield canonical quiet NaN 0x7FC00000.
REQ-017 Inf combined with any finite operand SHALL yield that infinity; two same-signed infinities SHALL yield that infinity.
REQ-018 Exponent field 0 SHALL be handled per the configuration section; the implicit leading bit is 1 only for nonzero exponent fields.
REQ-019 Results are exact for all operands that are exactly representable and need no rounding; for example, 1.5 + 0.5 = 0x40000000.

Reset
REQ-020 While reset_in is high, all pipeline registers and outputC SHALL clear to 0 asynchronously.
REQ-021 After reset_in deasserts, the first valid result appears 2 edges after the first sampled operands; in-flight operations at reset are discarded.

Configuration
REQ-022 Macro IEEE_ADDER_SUBNORMAL_EN defined: subnormal inputs SHALL use exponent 1 with implicit bit 0. Results below the normal range SHALL be produced as correctly rounded subnormals (gradual underflow).
REQ-023 Macro undefined: subnormal inputs SHALL be treated as zero of the same sign. Results below the normal range SHALL flush to zero with the computed sign.

Verification
REQ-024 A=0x3FC00000 (1.5), B=0x3F000000 (0.5), add_sub_bit=0 -> outputC=0x40000000 two edges later; with add_sub_bit=1 -> 0x3F800000.
REQ-025 A=0x40400000 (3.0), B=0xC0400000 (-3.0), add -> 0x00000000; A=B=0x80000000, add -> 0x80000000.
REQ-026 A=0x41000000 (8.0), B=0x3FC00000 (1.5), add -> 0x41180000; swapped operands -> same; A=0x40A00000 (5), B=0x40800000 (4), sub -> 0x3F800000.
REQ-027 A=0x80C00001, B=0x00800000, add -> 0x80400001 with IEEE_ADDER_SUBNORMAL_EN; 0x80000000 without it.
REQ-028 A=B=0x7F7FFFFF, add -> 0x7F800000; A=0x7F800000, B=0x7F800000, sub -> 0x7FC00000; A=0x7FC00000, B=any -> 0x7FC00000.
REQ-029 Back-to-back operands on consecutive cycles, with reset_in pulsed mid-stream -> each result appears exactly 2 edges after its inputs; outputC=0 during reset; no stale result after reset.
